scene_pixel_renderer: RTL and testbench
=======================================

Name: scene_pixel_renderer

Overview:
- Parametrised, pipelined per-pixel scene renderer that replaces the four fixed per-state renderers with one block.
- Supports N_OBS obstacles, a scrolling two-tone ground, and a mode-dependent look: menu, running, pause blink and game-over tint.
- Sits between the VGA pixel-coordinate generator and the framebuffer/VGA colour input.
- Drives an external dino sprite ROM with 1-cycle read latency.

Parameters:
- COORD_W, 8, width of x/y/positions/heights
- N_OBS, 4, number of obstacle channels
- OBS_W, 8, obstacle width in pixels
- DINO_LEFT, 10, dino left column
- DINO_W, 16, dino sprite width
- DINO_H, 16, dino sprite height
- GROUND_TOP, 100, first ground row
- BLINK_FRAMES, 16, frames per pause-blink half-period
- COL_BG / COL_GRND / COL_GRND_ALT, 3'b111 / 3'b010 / 3'b110, background / ground tones
- COL_OBS_EVEN / COL_OBS_ODD, 3'b001 / 3'b101, colours for even / odd obstacle indices
- COL_DEAD, 3'b100, dino colour in game-over mode
- COL_TRANSPARENT, 3'b000, sprite transparency key

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frameTick  in  1  one-cycle strobe at frame start; latches scene state
- mode  in  2  0=MENU, 1=RUNNING, 2=PAUSE, 3=OVER
- dinoY  in  COORD_W  dino top row
- obsX  in  N_OBS*COORD_W  packed obstacle left columns, obstacle i at [i*COORD_W +: COORD_W]
- obsH  in  N_OBS*COORD_W  packed obstacle heights
- obsEn  in  N_OBS  per-obstacle enable
- pixValid  in  1  x,y valid this cycle
- x, y  in  COORD_W  pixel coordinate
- spriteAddr  out  clog2(DINO_W*DINO_H)  sprite ROM address
- spriteData  in  3  ROM data, valid 1 cycle after spriteAddr
- outValid  out  1  color valid
- color  out  3  pixel colour

Behaviour:
- Scene latch: mode, dinoY, obsX, obsH and obsEn are captured into shadow registers only on frameTick. Mid-frame input changes never affect the current frame.
- Reset values: shadows mode=MENU, all others 0. Pipeline valids 0. outValid=0, color=COL_BG, spriteAddr=0. Scroll and blink counters 0, blink phase 0.
- Reset is effective in the same edge even mid-pipeline; all in-flight pixels are discarded.
- Pipeline, latency 2 cycles:
  - S0 (pixValid edge): register x, y and valid. Compute the dino hit. Drive spriteAddr = (y-dinoY)*DINO_W + (x-DINO_LEFT) on a hit, else 0.
  - S1: spriteData is available. Compute the ground, obstacle and final colour.
  - S2: register color and outValid.
  - Bubbles propagate: outValid=0 and color holds its last value.
- Arithmetic: all bound comparisons use COORD_W+1 bits, so dinoY+DINO_H and obsX+OBS_W do not wrap.
- Obstacle height: clamped to GROUND_TOP.
- Dino hit: DINO_LEFT<=x<DINO_LEFT+DINO_W and dinoY<=y<dinoY+DINO_H.
- Obstacle i hit: obsEn[i] and obsX[i]<=x<obsX[i]+OBS_W and GROUND_TOP-obsH[i]<=y<GROUND_TOP.
- Priority, highest first:
  1. Ground (y>=GROUND_TOP): COL_GRND_ALT if ((x+scroll)>>2)&1, else COL_GRND. The sum is mod 2^COORD_W.
  2. Dino (hit and spriteData!=COL_TRANSPARENT): spriteData, or COL_DEAD when mode=OVER.
  3. Obstacles: the lowest hit index wins; colour is COL_OBS_EVEN/ODD by index parity. Suppressed in MENU, and in PAUSE while blink phase=1.
  4. COL_BG.
- Scroll counter (COORD_W bits), updated on frameTick using the newly latched mode:
  - RUNNING: +1, wraps at 2^COORD_W.
  - MENU: cleared to 0.
  - PAUSE/OVER: holds.
- Blink counter, updated on frameTick:
  - In PAUSE: counts 0..BLINK_FRAMES-1; on wrap, phase toggles.
  - Any other mode: counter and phase cleared.
- Simultaneous frameTick and pixValid: the pixel uses the new shadows. All S0 decisions read the shadows after the edge they are latched on.

Test Plan:
- Reset, then pixel (2,110) -> outValid=1 exactly 2 cycles later; color=COL_GRND (scroll 0, (2>>2)&1=0).
- frameTick with mode=RUNNING, dinoY=50; pixel (12,52) -> spriteAddr=34 next cycle. With ROM returning 3'b011, color=3'b011. With ROM returning 3'b000 and no obstacles, color=COL_BG.
- obsX0=obsX1=40, obsH0=obsH1=20, obsEn=2'b11, RUNNING; pixel (45,85) -> COL_OBS_EVEN. With obsEn=2'b10 -> COL_OBS_ODD. Pixel (45,79) -> COL_BG. Change obsEn mid-frame without frameTick -> output unchanged.
- Four RUNNING frameTicks, pixel (0,110) -> COL_GRND_ALT (scroll=4). One MENU frameTick, same pixel -> COL_GRND (scroll=0). 256 RUNNING ticks -> scroll wraps to 0.
- PAUSE, obstacle pixel (45,85):
  - Ticks 1-15 -> COL_OBS_EVEN.
  - After tick 16 -> COL_BG.
  - After tick 32 -> COL_OBS_EVEN.
  - One RUNNING tick -> phase cleared, obstacle visible.
- OVER: dino pixel with ROM data 3'b011 -> COL_DEAD. Assert reset while pipeline holds 2 valid pixels -> next cycle outValid=0, color=COL_BG, and mode reverts to MENU.

Source files
------------

// File: rtl/scene_pixel_renderer.sv
// Per-pixel scene renderer: frame-latched scene state, a two-stage colour pipeline
// with ground/dino/obstacle priority, and a 1-cycle external dino sprite ROM.
module scene_pixel_renderer #(
  parameter int         COORD_W         = 8,
  parameter int         N_OBS           = 4,
  parameter int         OBS_W           = 8,
  parameter int         DINO_LEFT       = 10,
  parameter int         DINO_W          = 16,
  parameter int         DINO_H          = 16,
  parameter int         GROUND_TOP      = 100,
  parameter int         BLINK_FRAMES    = 16,
  parameter logic [2:0] COL_BG          = 3'b111,
  parameter logic [2:0] COL_GRND        = 3'b010,
  parameter logic [2:0] COL_GRND_ALT    = 3'b110,
  parameter logic [2:0] COL_OBS_EVEN    = 3'b001,
  parameter logic [2:0] COL_OBS_ODD     = 3'b101,
  parameter logic [2:0] COL_DEAD        = 3'b100,
  parameter logic [2:0] COL_TRANSPARENT = 3'b000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 frameTick,
  input  logic [1:0]                           mode,
  input  logic [COORD_W-1:0]                   dinoY,
  input  logic [N_OBS*COORD_W-1:0]             obsX,
  input  logic [N_OBS*COORD_W-1:0]             obsH,
  input  logic [N_OBS-1:0]                     obsEn,
  input  logic                                 pixValid,
  input  logic [COORD_W-1:0]                   x,
  input  logic [COORD_W-1:0]                   y,
  output logic [$clog2(DINO_W*DINO_H)-1:0]     spriteAddr,
  input  logic [2:0]                           spriteData,
  output logic                                 outValid,
  output logic [2:0]                           color
);

  localparam int ADDR_W = $clog2(DINO_W * DINO_H);
  localparam int EW     = COORD_W + 1;
  localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0] MODE_MENU  = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_PAUSE = 2'd2;
  localparam logic [1:0] MODE_OVER  = 2'd3;

  localparam logic [EW-1:0] GT_E = EW'(GROUND_TOP);

  function automatic logic [EW-1:0] ext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic [EW-1:0] clamp_h(input logic [COORD_W-1:0] h);
    return (ext(h) > GT_E) ? GT_E : ext(h);
  endfunction

  logic [1:0]               r_mode;
  logic [COORD_W-1:0]       r_dino_y;
  logic [N_OBS*COORD_W-1:0] r_obs_x;
  logic [N_OBS*COORD_W-1:0] r_obs_h;
  logic [N_OBS-1:0]         r_obs_en;
  logic [COORD_W-1:0]       r_scroll;
  logic [BW-1:0]            r_blink_cnt;
  logic                     r_blink_ph;

  // Scroll and blink react to the mode being latched on this tick, not the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= MODE_MENU;
      r_dino_y    <= '0;
      r_obs_x     <= '0;
      r_obs_h     <= '0;
      r_obs_en    <= '0;
      r_scroll    <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (frameTick) begin
      r_mode   <= mode;
      r_dino_y <= dinoY;
      r_obs_x  <= obsX;
      r_obs_h  <= obsH;
      r_obs_en <= obsEn;
      case (mode)
        MODE_RUN:  r_scroll <= r_scroll + COORD_W'(1);
        MODE_MENU: r_scroll <= '0;
        default:   r_scroll <= r_scroll;
      endcase
      if (mode == MODE_PAUSE) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end else begin
        r_blink_cnt <= '0;
        r_blink_ph  <= 1'b0;
      end
    end
  end

  // ---- Stage 0: registered coordinate, dino hit, sprite address, ground, obstacles
  logic               r_vld_p0;
  logic [COORD_W-1:0] r_x_p0;
  logic [COORD_W-1:0] r_y_p0;

  always_ff @(posedge clk) begin
    if (reset) r_vld_p0 <= 1'b0;
    else       r_vld_p0 <= pixValid;
  end

  always_ff @(posedge clk) begin
    r_x_p0 <= x;
    r_y_p0 <= y;
  end

  logic [EW-1:0]     w_x_e;
  logic [EW-1:0]     w_y_e;
  logic [EW-1:0]     w_dino_y_e;
  logic              w_dino_hit;
  logic [ADDR_W-1:0] w_dy;
  logic [ADDR_W-1:0] w_dx;
  logic [ADDR_W-1:0] w_addr;

  assign w_x_e      = ext(r_x_p0);
  assign w_y_e      = ext(r_y_p0);
  assign w_dino_y_e = ext(r_dino_y);

  assign w_dino_hit = (w_x_e >= EW'(DINO_LEFT)) && (w_x_e < EW'(DINO_LEFT + DINO_W)) &&
                      (w_y_e >= w_dino_y_e) && (w_y_e < w_dino_y_e + EW'(DINO_H));

  assign w_dy       = ADDR_W'(r_y_p0 - r_dino_y);
  assign w_dx       = ADDR_W'(r_x_p0 - COORD_W'(DINO_LEFT));
  assign w_addr     = w_dy * ADDR_W'(DINO_W) + w_dx;
  assign spriteAddr = (r_vld_p0 && w_dino_hit) ? w_addr : '0;

  logic       w_is_gnd;
  logic [2:0] w_gnd_col;

  assign w_is_gnd  = (w_y_e >= GT_E);
  assign w_gnd_col = (|((r_x_p0 + r_scroll) & COORD_W'(4))) ? COL_GRND_ALT : COL_GRND;

  logic [N_OBS-1:0] w_obs_vec;

  for (genvar g = 0; g < N_OBS; g++) begin : g_obs
    logic [EW-1:0] w_ox;
    logic [EW-1:0] w_top;
    assign w_ox  = ext(r_obs_x[g*COORD_W +: COORD_W]);
    assign w_top = GT_E - clamp_h(r_obs_h[g*COORD_W +: COORD_W]);
    assign w_obs_vec[g] = r_obs_en[g] &&
                          (w_x_e >= w_ox) && (w_x_e < w_ox + EW'(OBS_W)) &&
                          (w_y_e >= w_top) && (w_y_e < GT_E);
  end

  logic       w_obs_hit;
  logic       w_obs_odd;
  logic       w_obs_show;
  logic [2:0] w_back_col;

  // Walk from the top index down so the lowest hitting index is the one left standing.
  always_comb begin
    w_obs_hit = 1'b0;
    w_obs_odd = 1'b0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      if (w_obs_vec[i]) begin
        w_obs_hit = 1'b1;
        w_obs_odd = (i % 2 == 1);
      end
    end
  end

  assign w_obs_show = (r_mode != MODE_MENU) && !((r_mode == MODE_PAUSE) && r_blink_ph);
  assign w_back_col = (w_obs_hit && w_obs_show) ? (w_obs_odd ? COL_OBS_ODD : COL_OBS_EVEN)
                                                : COL_BG;

  // ---- Stage 1: sprite data arrives, resolve final colour
  logic       r_vld_p1;
  logic       r_gnd_p1;
  logic [2:0] r_gnd_col_p1;
  logic       r_dino_p1;
  logic       r_dead_p1;
  logic [2:0] r_back_col_p1;

  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= r_vld_p0;
  end

  always_ff @(posedge clk) begin
    r_gnd_p1      <= w_is_gnd;
    r_gnd_col_p1  <= w_gnd_col;
    r_dino_p1     <= w_dino_hit;
    r_dead_p1     <= (r_mode == MODE_OVER);
    r_back_col_p1 <= w_back_col;
  end

  logic [2:0] w_pix_col;

  always_comb begin
    w_pix_col = r_back_col_p1;
    if (r_gnd_p1) begin
      w_pix_col = r_gnd_col_p1;
    end else if (r_dino_p1 && (spriteData != COL_TRANSPARENT)) begin
      w_pix_col = r_dead_p1 ? COL_DEAD : spriteData;
    end
  end

  // ---- Stage 2: output register; colour holds through bubbles
  logic       r_out_vld;
  logic [2:0] r_color;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_color   <= COL_BG;
    end else begin
      r_out_vld <= r_vld_p1;
      if (r_vld_p1) r_color <= w_pix_col;
    end
  end

  assign outValid = r_out_vld;
  assign color    = r_color;

endmodule

// File: tb/tb_scene_pixel_renderer.sv
// Directed bench for scene_pixel_renderer: stimulus pushes expected colours into a
// queue, a negedge monitor pops and compares whenever outValid is high.
module tb_scene_pixel_renderer;
  localparam int CW = 8;
  localparam int NO = 4;
  localparam int AW = 8;
  localparam logic [2:0] BG   = 3'b111;
  localparam logic [2:0] GR   = 3'b010;
  localparam logic [2:0] GA   = 3'b110;
  localparam logic [2:0] OE   = 3'b001;
  localparam logic [2:0] OO   = 3'b101;
  localparam logic [2:0] DEAD = 3'b100;
  localparam logic [1:0] M_MENU = 2'd0, M_RUN = 2'd1, M_PAUSE = 2'd2, M_OVER = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          frameTick;
  logic [1:0]    mode;
  logic [CW-1:0] dinoY;
  logic [NO*CW-1:0] obsX;
  logic [NO*CW-1:0] obsH;
  logic [NO-1:0] obsEn;
  logic          pixValid;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [AW-1:0] spriteAddr;
  logic [2:0]    spriteData;
  logic          outValid;
  logic [2:0]    color;
  logic [2:0]    rom_val;

  scene_pixel_renderer dut (
    .clk(clk), .reset(reset), .frameTick(frameTick), .mode(mode), .dinoY(dinoY),
    .obsX(obsX), .obsH(obsH), .obsEn(obsEn), .pixValid(pixValid), .x(x), .y(y),
    .spriteAddr(spriteAddr), .spriteData(spriteData), .outValid(outValid), .color(color)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] col;
    int         cyc;
    string      name;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       armed = 1'b0;
  logic [2:0] last_col = BG;

  // Sprite ROM model: every address returns rom_val, one cycle late.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    spriteData <= rom_val;
  end

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (outValid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output color got %b want none", color);
        end else begin
          e = exp_q.pop_front();
          if (color !== e.col) begin
            errors++;
            $display("FAIL %s color got %b want %b", e.name, color, e.col);
          end
          checks++;
          if (cyc != e.cyc + 2) begin
            errors++;
            $display("FAIL %s latency got %0d want 2", e.name, cyc - e.cyc);
          end
          last_col = e.col;
        end
      end else begin
        checks++;
        if (color !== last_col) begin
          errors++;
          $display("FAIL bubble_hold color got %b want %b", color, last_col);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [1:0] m);
    @(negedge clk);
    mode      = m;
    frameTick = 1'b1;
    @(posedge clk);
    #1 frameTick = 1'b0;
  endtask

  task automatic pix(input string nm, input int px, input int py, input logic [2:0] rom,
                     input logic [2:0] ec, input int ea);
    exp_t e;
    @(negedge clk);
    x        = CW'(px);
    y        = CW'(py);
    rom_val  = rom;
    pixValid = 1'b1;
    @(posedge clk);
    #1;
    e.col  = ec;
    e.cyc  = cyc;
    e.name = nm;
    exp_q.push_back(e);
    if (ea >= 0) chk({nm, "_addr"}, 32'(spriteAddr), 32'(ea));
    pixValid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout outValid never rose, want %b", nm, ec);
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frameTick = 1'b0; mode = M_MENU; dinoY = '0;
    obsX = '0; obsH = '0; obsEn = '0; pixValid = 1'b0; x = '0; y = '0; rom_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_color", 32'(color), 32'(BG));
    chk("rst_addr", 32'(spriteAddr), 32'd0);
    reset = 1'b0; last_col = BG; armed = 1'b1;

    pix("gnd_after_rst", 2, 110, 3'b000, GR, -1);

    dinoY = 8'd50;
    tick(M_RUN);
    pix("dino_rom", 12, 52, 3'b011, 3'b011, 34);
    pix("dino_transp", 12, 52, 3'b000, BG, 34);
    pix("dino_right_edge", 25, 50, 3'b011, 3'b011, 15);
    pix("dino_past_right", 26, 50, 3'b011, BG, 0);
    pix("dino_above_top", 12, 49, 3'b011, BG, 0);

    obsX = {8'd0, 8'd0, 8'd40, 8'd40}; obsH = {8'd0, 8'd0, 8'd20, 8'd20}; obsEn = 4'b0011;
    tick(M_RUN);
    pix("obs_even", 45, 85, 3'b000, OE, -1);
    obsEn = 4'b0010;
    tick(M_RUN);
    pix("obs_odd", 45, 85, 3'b000, OO, -1);
    pix("obs_above", 45, 79, 3'b000, BG, -1);
    pix("obs_bottom_row", 45, 99, 3'b000, OO, -1);
    pix("gnd_over_obs", 45, 100, 3'b000, GR, -1);
    obsEn = 4'b0011;
    pix("midframe_hold", 45, 85, 3'b000, OO, -1);

    obsX = {8'd0, 8'd0, 8'd40, 8'd12}; obsH = {8'd0, 8'd0, 8'd20, 8'd60};
    tick(M_RUN);
    pix("dino_over_obs", 14, 60, 3'b011, 3'b011, 164);
    pix("transp_shows_obs", 14, 60, 3'b000, OE, 164);

    obsX = {8'd0, 8'd0, 8'd252, 8'd40}; obsH = {8'd0, 8'd0, 8'd10, 8'd200};
    tick(M_RUN);
    pix("obs_height_clamp", 45, 0, 3'b000, OE, -1);
    pix("obs_x_nowrap", 255, 95, 3'b000, OO, -1);
    pix("obs_x_nowrap_miss", 3, 95, 3'b000, BG, -1);

    tick(M_MENU);
    for (int k = 0; k < 4; k++) tick(M_RUN);
    pix("scroll4_alt", 0, 110, 3'b000, GA, -1);
    tick(M_MENU);
    pix("menu_clears_scroll", 0, 110, 3'b000, GR, -1);
    pix("menu_hides_obs", 45, 0, 3'b000, BG, -1);
    for (int k = 0; k < 255; k++) tick(M_RUN);
    pix("scroll255", 0, 110, 3'b000, GA, -1);
    pix("scroll_sum_wrap", 1, 110, 3'b000, GR, -1);
    tick(M_RUN);
    pix("scroll_wrap0", 0, 110, 3'b000, GR, -1);
    pix("scroll_wrap0_alt", 4, 110, 3'b000, GA, -1);

    obsX = {8'd0, 8'd0, 8'd40, 8'd40}; obsH = {8'd0, 8'd0, 8'd20, 8'd20}; obsEn = 4'b0011;
    tick(M_RUN);
    for (int k = 1; k <= 15; k++) begin
      tick(M_PAUSE);
      pix("pause_visible", 45, 85, 3'b000, OE, -1);
    end
    tick(M_PAUSE);
    pix("pause_blink16", 45, 85, 3'b000, BG, -1);
    for (int k = 17; k <= 31; k++) tick(M_PAUSE);
    pix("pause_blink31", 45, 85, 3'b000, BG, -1);
    tick(M_PAUSE);
    pix("pause_blink32", 45, 85, 3'b000, OE, -1);
    for (int k = 33; k <= 48; k++) tick(M_PAUSE);
    pix("pause_blink48", 45, 85, 3'b000, BG, -1);
    tick(M_RUN);
    pix("run_clears_phase", 45, 85, 3'b000, OE, -1);

    dinoY = 8'd50;
    tick(M_OVER);
    pix("over_dead", 12, 52, 3'b011, DEAD, 34);
    pix("over_obs", 45, 85, 3'b000, OE, -1);

    @(negedge clk);
    x = 8'd12; y = 8'd52; rom_val = 3'b011; pixValid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 armed = 1'b0; pixValid = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_outValid", 32'(outValid), 32'd0);
    chk("midrst_color", 32'(color), 32'(BG));
    chk("midrst_addr", 32'(spriteAddr), 32'd0);
    reset = 1'b0; exp_q.delete(); last_col = BG; armed = 1'b1;
    repeat (3) @(posedge clk);
    pix("post_rst_menu", 12, 2, 3'b011, 3'b011, 34);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
